// File: rtl/rv32i_pkg.sv
// RV32I opcode/ALU-op constants and decode helpers shared by the decode stage.
// Optional build macro used by consumers: ID_ILLEGAL_CHECK_EN.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [15:0] ALU_ADD  = 16'h0033;
  localparam logic [15:0] ALU_SUB  = 16'h8033;
  localparam logic [15:0] ALU_SRA  = 16'h82b3;
  localparam logic [15:0] ALU_ADDI = 16'h0013;
  localparam logic [15:0] ALU_SRAI = 16'h8293;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode, input logic [2:0] funct3);
    imm_fmt_e fmt;
    fmt = FMT_R;
    case (opcode)
      OP_LOAD, OP_JALR:  fmt = FMT_I;
      OP_IMM:            fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
      OP_STORE:          fmt = FMT_S;
      OP_BRANCH:         fmt = FMT_B;
      OP_LUI, OP_AUIPC:  fmt = FMT_U;
      OP_JAL:            fmt = FMT_J;
      default:           fmt = FMT_R;
    endcase
    return fmt;
  endfunction

  function automatic logic [15:0] alu_op(input logic [31:0] instr);
    logic       mod;
    logic [2:0] f3;
    mod = (instr[6:0] == OP_R) || (instr[6:0] == OP_IMM && instr[14:12] == 3'b101)
          ? instr[30] : 1'b0;
    f3  = (instr[6:0] == OP_LUI || instr[6:0] == OP_AUIPC || instr[6:0] == OP_JAL)
          ? 3'b000 : instr[14:12];
    return {mod, 5'b00000, f3, instr[6:0]};
  endfunction

  function automatic logic is_illegal(input logic [31:0] instr);
    logic       ill;
    logic [6:0] f7;
    logic [2:0] f3;
    f7  = instr[31:25];
    f3  = instr[14:12];
    ill = (instr[1:0] != 2'b11);
    case (instr[6:0])
      OP_R: begin
        if (!(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
          ill = 1'b1;
      end
      OP_IMM: begin
        if (f3 == 3'b001 && f7 != 7'b0000000)
          ill = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
          ill = 1'b1;
      end
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: ;
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Combinational RV32I immediate generator; shift-immediates yield the bare shamt.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_fmt(instr[6:0], instr[14:12]))
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_SH:  imm = {27'b0, instr[24:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Single-register RV32I decode stage with valid/ready handshake and flush.
// Define ID_ILLEGAL_CHECK_EN to flag illegal encodings (out_illegal, out_op forced to 0).
module id_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  output logic [15:0] out_op,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  logic [31:0] imm_d;
  logic [15:0] op_d;
  logic        illegal_d;
  logic        accept;

  imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm_d)
  );

  assign in_ready = !out_valid || out_ready;
  // Flush masks acceptance even though in_ready follows the plain handshake rule.
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    op_d      = alu_op(in_instr);
    illegal_d = 1'b0;
`ifdef ID_ILLEGAL_CHECK_EN
    illegal_d = is_illegal(in_instr);
    if (illegal_d)
      op_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_imm     <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_op      <= op_d;
      out_imm     <= imm_d;
      out_rs1     <= in_instr[19:15];
      out_rs2     <= in_instr[24:20];
      out_rd      <= in_instr[11:7];
      out_illegal <= illegal_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports: clk in 1 (rising-edge clock); rst in 1 (reset, synchronous, active-high).
REQ-002 SHALL have ports: in_valid in 1; in_ready out 1; in_instr in 32 (RV32I instruction word).
REQ-003 SHALL have ports: out_valid out 1; out_ready in 1; flush in 1 (discard held decode).
REQ-004 SHALL have ports: out_op out 16 (ALU op code); out_imm out 32; out_rs1 out 5; out_rs2 out 5; out_rd out 5; out_illegal out 1.

Function
REQ-005 SHALL compute out_op as: bit15 = funct7 modifier, bits[14:10] = 0, bits[9:7] = funct3, bits[6:0] = opcode. For example, add = 16'h0033, sub = 16'h8033, sra = 16'h82b3, addi = 16'h0013.
REQ-006 SHALL set bit15 = instr[30] for opcode 0110011, and for opcode 0010011 with funct3 = 101. Bit15 SHALL be 0 in all other cases.
REQ-007 SHALL force bits[9:7] = 0 for LUI, AUIPC and JAL.
REQ-008 SHALL produce out_imm per format, sign-extended from instr[31]:
- I-type: load, JALR and ALU-imm.
- S-type and B-type: bit0 = 0.
- U-type: low 12 bits = 0.
- J-type: bit0 = 0.
- R-type: out_imm = 0.
REQ-009 SHALL output out_imm = {27'b0, shamt} for the shift-immediate forms SLLI, SRLI and SRAI.
REQ-010 SHALL pass instr[19:15], [24:20] and [11:7] to out_rs1, out_rs2 and out_rd unconditionally.
REQ-011 SHALL be a single registered stage with latency 1: a word accepted at edge N appears on the outputs with out_valid = 1 after edge N.
REQ-012 SHALL drive in_ready = !out_valid || out_ready (combinational); an input word is accepted when in_valid && in_ready.
REQ-013 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-014 SHALL clear out_valid when out_ready is high and no word is accepted in the same cycle.
REQ-015 SHALL handle a simultaneous drain and accept by loading the new word, keeping out_valid = 1 (full throughput, no bubble).
REQ-016 SHALL give flush priority over everything: next cycle out_valid = 0 and no input is accepted, regardless of in_valid and out_ready.
REQ-017 SHALL leave data outputs don't-care when out_valid = 0; the bench SHALL check them only while out_valid = 1.

Reset
REQ-018 SHALL, on rst high at a clock edge, clear out_valid, out_op, out_imm, out_rs1, out_rs2, out_rd and out_illegal to 0.
REQ-019 SHALL drop any held word when reset is asserted mid-operation; in_ready SHALL read 1 in the first cycle after reset.

Configuration
REQ-020 SHALL, with ID_ILLEGAL_CHECK_EN defined, set out_illegal = 1 and force out_op = 16'h0000 for any of:
- instr[1:0] != 11;
- an opcode outside the RV32I set;
- an R-type funct7 other than 0000000, or other than 0100000 with funct3 000/101;
- a shift-immediate with an invalid funct7.
REQ-021 SHALL, without ID_ILLEGAL_CHECK_EN, tie out_illegal to 0 and emit out_op per REQ-005 for any word.

Structure
REQ-022 SHALL take the following from shared package rv32i_pkg: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC) and the ALU op-code constants of REQ-005.
REQ-023 SHALL place immediate generation in one combinational sub-module, imm_gen (in 32, out 32); handshake and registers stay in id_stage.

Verification
REQ-024 SHALL cover: in_instr 0x002081B3 (add x3,x1,x2) -> next cycle out_op 0x0033, rs1 1, rs2 2, rd 3, imm 0, out_valid 1.
REQ-025 SHALL cover: 0x402081B3 -> out_op 0x8033; 0xFFF00093 (addi x1,x0,-1) -> out_op 0x0013, out_imm 0xFFFFFFFF.
REQ-026 SHALL cover: 0x40335293 (srai x5,x6,3) -> out_op 0x8293, out_imm 0x00000003, rs1 6, rd 5.
REQ-027 SHALL cover the stall: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and outputs unchanged. Then out_ready = 1 -> the next word is loaded with no bubble cycle.
REQ-028 SHALL cover: flush together with in_valid and out_ready -> out_valid 0 next cycle and the word is not accepted. Also rst mid-stall -> all outputs 0.
REQ-029 SHALL cover, with ID_ILLEGAL_CHECK_EN: 0x00000000 and 0xFE2081B3 -> out_illegal 1, out_op 0x0000. Without the macro: out_illegal 0.
